spi_flash_cmd_tracker: RTL
==========================

Name: spi_flash_cmd_tracker

Overview:
Sequencer that sits on the logical byte interface of the qspi_sync SPI receiver and tracks the phase of each SPI flash transaction: command, address, dummy and data. It assembles the flash address, reports address/data timing to the PSRAM emulation path, and queues command/address report records for the UART. It paces the UART output with a ready handshake and drops whole records when the queue is full.

Parameters:
ADDR_BYTES, 3, number of address bytes per addressed command (3 or 4); address width AW = 8*ADDR_BYTES.
REPORT_DEPTH, 8, report record FIFO depth (power of 2, >= 2).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
spi_cs  in  1  raw flash !CS (high = deselected)
byte_strobe  in  1  one-cycle pulse when a byte has been received from qspi_sync
start_strobe  in  1  qualifies byte_strobe as the first byte after !CS fell
byte  in  8  received byte, valid with byte_strobe
cmd  out  8  latched current command
cmd_strobe  out  1  one-cycle pulse when a command byte is latched
addr  out  AW  assembled address, MSB first
addr_strobe  out  1  one-cycle pulse when the final address byte is latched
data_strobe  out  1  one-cycle pulse per data-phase byte
data_index  out  16  index of the current data byte (0-based), saturating at 0xFFFF
busy  out  1  high in any state other than IDLE
uart_tx  out  8  report byte
uart_tx_strobe  out  1  one-cycle pulse; only asserted when uart_tx_ready = 1
uart_tx_ready  in  1  UART accepts a byte in this cycle
drop_count  out  8  records dropped on a full FIFO, saturating at 0xFF

Behaviour:
- Reset (asynchronous) clears all state:
  - state = IDLE.
  - All outputs 0.
  - FIFO empty; serializer idle.
- States:
  - IDLE, ADDR, DUMMY, DATA.
  - ADDR_CNT counts received address bytes; DUMMY_CNT counts dummy bytes remaining.
- Command classes (constants):
  - 0x03: addr, 0 dummy.
  - 0x0B: addr, 1 dummy.
  - 0x6B: addr, 1 dummy.
  - 0xEB: addr, 3 dummy.
  - 0x02: addr, 0 dummy.
  - 0x20: addr, 0 dummy.
  - 0xD8: addr, 0 dummy.
  - All others: no address, go straight to DATA.
- byte_strobe & start_strobe in any state:
  - Latch cmd; pulse cmd_strobe; clear addr, ADDR_CNT and data_index.
  - Next state ADDR if the command takes an address, else DATA.
  - This aborts any command in progress (its report is not pushed).
  - No-address commands push a 1-byte record {cmd} in the same cycle.
- ADDR: each byte_strobe does addr <= {addr[AW-9:0], byte}.
  - On the ADDR_BYTES-th byte: pulse addr_strobe in the following cycle, with addr final.
  - Push a record {cmd, addr bytes MSB first} of length 1+ADDR_BYTES.
  - Next state DUMMY if dummy > 0, else DATA.
- DUMMY: each byte_strobe decrements DUMMY_CNT; at 0 go to DATA. No data_strobe.
- DATA: each byte_strobe pulses data_strobe with the current data_index, then data_index increments (saturating).
- spi_cs high: state -> IDLE on the next clk.
  - Partial address is discarded; no addr_strobe and no record.
  - cmd and addr hold their values.
- byte_strobe without start_strobe in IDLE is ignored.
- Report FIFO:
  - Record = length (1 or 1+ADDR_BYTES) + 8*(1+ADDR_BYTES) bits.
  - Push when full: record discarded, drop_count++ (saturating).
  - Push and pop in the same cycle when full: the pop occurs first, so the push succeeds.
- Serializer:
  - Pops a record, then emits bytes MSB-first, one per cycle while uart_tx_ready = 1.
  - Holds the current byte while uart_tx_ready = 0.
  - Latency: a record pushed into an empty FIFO yields its first uart_tx_strobe 2 cycles after the push with ready = 1.
- Record emission is never truncated by spi_cs or a new command; only reset clears it.

Decomposition:
- Package spi_flash_pkg holds:
  - Opcode constants and state encoding.
  - A per-opcode function returning {has_addr, dummy_bytes}.
- Sub-module report_fifo_serializer holds the record FIFO, drop counter and UART pacing.
- The top-level block holds the phase FSM.

Test Plan:
- 0x03,0x00,0x12,0x34, then 4 data bytes, ready = 1 -> cmd_strobe; addr_strobe with addr = 0x001234; data_strobe ×4 with data_index 0..3; UART bytes 03 00 12 34.
- 0xEB,0xAB,0xCD,0xEF, then 3 dummy and 2 data bytes -> addr = 0xABCDEF; no data_strobe during the dummy bytes; data_index 0,1.
- 0x0B,0x12, then spi_cs high, then 0x9F,0xC2 -> no addr_strobe, no 0x0B record; UART emits only 9F; data_strobe once with index 0.
- uart_tx_ready = 0, 9 complete 0x03 commands -> 8 records queued, drop_count = 1; on raising ready, exactly 32 bytes are emitted in order.
- New start_strobe(0x02) during the DATA phase of 0x03 -> immediate restart: cmd = 0x02, data_index = 0, state ADDR.
- Assert reset mid-serialization (byte 2 of 4) -> uart_tx_strobe = 0 immediately, FIFO empty, drop_count = 0, busy = 0.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Shared opcode table, phase-FSM encoding and per-opcode decode for the SPI flash tracker.
// A command either carries an address (followed by a fixed dummy count) or goes straight to data.
package spi_flash_pkg;

    localparam logic [7:0] OP_READ          = 8'h03;
    localparam logic [7:0] OP_FAST_READ     = 8'h0B;
    localparam logic [7:0] OP_QUAD_OUT_READ = 8'h6B;
    localparam logic [7:0] OP_QUAD_IO_READ  = 8'hEB;
    localparam logic [7:0] OP_PAGE_PROG     = 8'h02;
    localparam logic [7:0] OP_SECTOR_ERASE  = 8'h20;
    localparam logic [7:0] OP_BLOCK_ERASE   = 8'hD8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_DUMMY = 2'd2,
        ST_DATA  = 2'd3
    } state_e;

    typedef struct packed {
        logic       has_addr;
        logic [1:0] dummy;
    } cmd_info_t;

    function automatic cmd_info_t cmd_info(input logic [7:0] op);
        cmd_info_t info;
        info = '{has_addr: 1'b0, dummy: 2'd0};
        case (op)
            OP_READ:          info = '{has_addr: 1'b1, dummy: 2'd0};
            OP_FAST_READ:     info = '{has_addr: 1'b1, dummy: 2'd1};
            OP_QUAD_OUT_READ: info = '{has_addr: 1'b1, dummy: 2'd1};
            OP_QUAD_IO_READ:  info = '{has_addr: 1'b1, dummy: 2'd3};
            OP_PAGE_PROG:     info = '{has_addr: 1'b1, dummy: 2'd0};
            OP_SECTOR_ERASE:  info = '{has_addr: 1'b1, dummy: 2'd0};
            OP_BLOCK_ERASE:   info = '{has_addr: 1'b1, dummy: 2'd0};
            default:          info = '{has_addr: 1'b0, dummy: 2'd0};
        endcase
        return info;
    endfunction

endpackage

// File: rtl/report_fifo_serializer.sv
// Record FIFO of command/address reports plus a byte serializer paced by the UART ready signal.
// UART handshake: a byte moves in every cycle o_uart_tx_strobe is high; the strobe is only raised while i_uart_tx_ready is high.
module report_fifo_serializer #(
    parameter int ADDR_BYTES = 3,
    parameter int DEPTH      = 8
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_push,
    input  logic [$clog2(ADDR_BYTES+2)-1:0] i_push_len,
    input  logic [8*(ADDR_BYTES+1)-1:0]   i_push_data,
    input  logic                          i_uart_tx_ready,
    output logic [7:0]                    o_uart_tx,
    output logic                          o_uart_tx_strobe,
    output logic [7:0]                    o_drop_count
);
    localparam int RW = 8 * (ADDR_BYTES + 1);
    localparam int LW = $clog2(ADDR_BYTES + 2);
    localparam int PW = $clog2(DEPTH);

    logic [LW+RW-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic [7:0]       r_drop_count;
    logic             r_active;
    logic [RW-1:0]    r_shift;
    logic [LW-1:0]    r_left;

    logic             w_empty;
    logic             w_full;
    logic             w_last;
    logic             w_pop;
    logic             w_push_ok;
    logic [LW+RW-1:0] w_head;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == (PW+1)'(DEPTH));
    assign w_last    = r_active && (r_left == LW'(1));
    // Pop only while the UART is ready, so a stalled UART leaves every record in the FIFO.
    assign w_pop     = !w_empty && i_uart_tx_ready && (!r_active || w_last);
    assign w_push_ok = i_push && (!w_full || w_pop);
    assign w_head    = r_mem[r_rd_ptr];

    assign o_uart_tx        = r_shift[RW-1 -: 8];
    assign o_uart_tx_strobe = r_active && i_uart_tx_ready;
    assign o_drop_count     = r_drop_count;

    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= {i_push_len, i_push_data};
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_drop_count <= 8'd0;
            r_active     <= 1'b0;
            r_shift      <= '0;
            r_left       <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end else if (i_push && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase

            if (w_pop) begin
                r_active <= 1'b1;
                r_shift  <= w_head[RW-1:0];
                r_left   <= w_head[LW+RW-1:RW];
            end else if (r_active && i_uart_tx_ready) begin
                r_shift <= r_shift << 8;
                r_left  <= r_left - LW'(1);
                if (w_last) begin
                    r_active <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/spi_flash_cmd_tracker.sv
// Phase tracker for SPI flash transactions (command, address, dummy, data) on the qspi_sync byte stream.
// Assembles the address, times data bytes and hands report records to the FIFO/serializer.
module spi_flash_cmd_tracker
    import spi_flash_pkg::*;
#(
    parameter int ADDR_BYTES   = 3,
    parameter int REPORT_DEPTH = 8
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_spi_cs,
    input  logic                    i_byte_strobe,
    input  logic                    i_start_strobe,
    input  logic [7:0]              i_byte,
    output logic [7:0]              o_cmd,
    output logic                    o_cmd_strobe,
    output logic [8*ADDR_BYTES-1:0] o_addr,
    output logic                    o_addr_strobe,
    output logic                    o_data_strobe,
    output logic [15:0]             o_data_index,
    output logic                    o_busy,
    output logic [7:0]              o_uart_tx,
    output logic                    o_uart_tx_strobe,
    input  logic                    i_uart_tx_ready,
    output logic [7:0]              o_drop_count,
    output logic [1:0]              o_state
);
    localparam int AW = 8 * ADDR_BYTES;
    localparam int RW = 8 * (ADDR_BYTES + 1);
    localparam int LW = $clog2(ADDR_BYTES + 2);
    localparam int CW = $clog2(ADDR_BYTES + 1);

    state_e          r_state;
    state_e          w_next_state;
    logic [7:0]      r_cmd;
    logic            r_cmd_strobe;
    logic [AW-1:0]   r_addr;
    logic            r_addr_strobe;
    logic [CW-1:0]   r_addr_cnt;
    logic [1:0]      r_dummy_cnt;
    logic            r_data_strobe;
    logic [15:0]     r_data_index;
    logic [15:0]     r_data_next;

    logic            w_start;
    logic            w_byte;
    cmd_info_t       w_info;
    logic            w_last_addr;
    logic            w_push;
    logic [LW-1:0]   w_push_len;
    logic [RW-1:0]   w_push_data;

    // A deselected chip masks all bytes; the FSM falls back to IDLE on the next edge.
    assign w_start = i_byte_strobe && i_start_strobe && !i_spi_cs;
    assign w_byte  = i_byte_strobe && !i_spi_cs;
    assign w_info  = cmd_info(i_byte);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_push       = 1'b0;
        w_push_len   = '0;
        w_push_data  = '0;
        w_last_addr  = 1'b0;
        if (i_spi_cs) begin
            w_next_state = ST_IDLE;
        end else if (w_start) begin
            w_next_state = w_info.has_addr ? ST_ADDR : ST_DATA;
            if (!w_info.has_addr) begin
                w_push      = 1'b1;
                w_push_len  = LW'(1);
                w_push_data = {i_byte, {AW{1'b0}}};
            end
        end else if (i_byte_strobe) begin
            case (r_state)
                ST_ADDR: begin
                    if (r_addr_cnt == CW'(ADDR_BYTES - 1)) begin
                        w_last_addr  = 1'b1;
                        w_push       = 1'b1;
                        w_push_len   = LW'(ADDR_BYTES + 1);
                        w_push_data  = {r_cmd, r_addr[AW-9:0], i_byte};
                        w_next_state = (r_dummy_cnt != 2'd0) ? ST_DUMMY : ST_DATA;
                    end
                end
                ST_DUMMY: begin
                    if (r_dummy_cnt == 2'd1) begin
                        w_next_state = ST_DATA;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath: strobes are registered, so each appears the cycle after its byte with final values.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cmd         <= 8'd0;
            r_cmd_strobe  <= 1'b0;
            r_addr        <= '0;
            r_addr_strobe <= 1'b0;
            r_addr_cnt    <= '0;
            r_dummy_cnt   <= 2'd0;
            r_data_strobe <= 1'b0;
            r_data_index  <= 16'd0;
            r_data_next   <= 16'd0;
        end else begin
            r_cmd_strobe  <= 1'b0;
            r_addr_strobe <= 1'b0;
            r_data_strobe <= 1'b0;
            if (w_start) begin
                r_cmd        <= i_byte;
                r_cmd_strobe <= 1'b1;
                r_addr       <= '0;
                r_addr_cnt   <= '0;
                r_dummy_cnt  <= w_info.dummy;
                r_data_index <= 16'd0;
                r_data_next  <= 16'd0;
            end else if (w_byte) begin
                case (r_state)
                    ST_ADDR: begin
                        r_addr        <= {r_addr[AW-9:0], i_byte};
                        r_addr_cnt    <= r_addr_cnt + CW'(1);
                        r_addr_strobe <= w_last_addr;
                    end
                    ST_DUMMY: begin
                        r_dummy_cnt <= r_dummy_cnt - 2'd1;
                    end
                    ST_DATA: begin
                        r_data_strobe <= 1'b1;
                        r_data_index  <= r_data_next;
                        if (r_data_next != 16'hFFFF) begin
                            r_data_next <= r_data_next + 16'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign o_cmd         = r_cmd;
    assign o_cmd_strobe  = r_cmd_strobe;
    assign o_addr        = r_addr;
    assign o_addr_strobe = r_addr_strobe;
    assign o_data_strobe = r_data_strobe;
    assign o_data_index  = r_data_index;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_state       = r_state;

    report_fifo_serializer #(
        .ADDR_BYTES (ADDR_BYTES),
        .DEPTH      (REPORT_DEPTH)
    ) u_report (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_push           (w_push),
        .i_push_len       (w_push_len),
        .i_push_data      (w_push_data),
        .i_uart_tx_ready  (i_uart_tx_ready),
        .o_uart_tx        (o_uart_tx),
        .o_uart_tx_strobe (o_uart_tx_strobe),
        .o_drop_count     (o_drop_count)
    );

endmodule
